// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multi-bank program memory, PC sequencing and registered instruction fetch
module instr_fetch_unit #(
  parameter int INST_W      = 9,
  parameter int PC_W        = 8,
  parameter int NUM_PROGS   = 3,
  parameter int LONG_OFF_W  = 5,
  parameter int SHORT_OFF_W = 3,
  parameter int CNT_W       = 16,
  localparam int IMM_W      = LONG_OFF_W + 1,
  localparam int PS_W       = $clog2(NUM_PROGS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              fetch_en,
  input  logic              branch,
  input  logic [PC_W-1:0]   target,
  input  logic              branchi,
  input  logic              jump,
  input  logic [IMM_W-1:0]  imm,
  input  logic              ld_en,
  input  logic [PS_W-1:0]   ld_prog,
  input  logic [PC_W-1:0]   ld_addr,
  input  logic [INST_W-1:0] ld_data,
  output logic [PC_W-1:0]   pc_o,
  output logic [PS_W-1:0]   prog_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid,
  output logic [CNT_W-1:0]  fetch_cnt
);
  localparam int DEPTH = 2 ** PC_W;
  localparam int BI_W = NUM_PROGS > 1 ? $clog2(NUM_PROGS) : 1;
  localparam logic [PS_W-1:0] NP = PS_W'(NUM_PROGS);
  logic [INST_W-1:0] mem [NUM_PROGS][DEPTH];
  logic [PC_W-1:0] pc_q, pc_d, mag, rel;
  logic [PS_W-1:0] prog_q, prog_d;
  logic [INST_W-1:0] inst_q, inst_d, rd;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic neg;
  // next PC/program/count and the word that will sit at the next PC
  always_comb begin
    neg = jump ? imm[LONG_OFF_W] : imm[SHORT_OFF_W];
    mag = jump ? PC_W'(imm[LONG_OFF_W-1:0]) : PC_W'(imm[SHORT_OFF_W-1:0]);
    rel = neg ? pc_q - mag : pc_q + mag;
    pc_d = init ? start_addr : !fetch_en ? pc_q : branch ? target : branchi ? rel : pc_q + PC_W'(1);
    prog_d = !init ? prog_q : prog_q == NP ? PS_W'(1) : prog_q + PS_W'(1);
    cnt_d = init ? '0 : (!fetch_en || &cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    rd = mem[BI_W'(prog_d - PS_W'(1))][pc_d];
    inst_d = !(init || fetch_en) ? inst_q : prog_d == '0 ? '0 : rd;
  end
  // state registers; instruction is fetched on the same edge the PC moves
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
      prog_q <= '0;
      inst_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      prog_q <= prog_d;
      inst_q <= inst_d;
      cnt_q <= cnt_d;
    end
  end
  // load port, independent of reset so banks survive it; read above sees the old word
  always_ff @(posedge clk) begin
    if (ld_en && ld_prog != '0 && ld_prog <= NP) mem[BI_W'(ld_prog - PS_W'(1))][ld_addr] <= ld_data;
  end
  assign pc_o = pc_q;
  assign prog_o = prog_q;
  assign inst_o = inst_q;
  assign inst_valid = prog_q != '0;
  assign fetch_cnt = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed test with a behavioural reference model of the fetch unit
module tb_instr_fetch_unit;
  logic clk = 0, reset, init, fetch_en, branch, branchi, jump, ld_en, inst_valid;
  logic [7:0] start_addr, target, ld_addr, pc_o;
  logic [5:0] imm;
  logic [1:0] ld_prog, prog_o;
  logic [8:0] ld_data, inst_o;
  logic [15:0] fetch_cnt;
  int n_vec = 0, n_bad = 0;
  bit chk_on = 0;
  int m_mem [1:3][256];
  int m_pc = 0, m_prog = 0, m_inst = 0, m_cnt = 0;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .init(init), .start_addr(start_addr), .fetch_en(fetch_en),
    .branch(branch), .target(target), .branchi(branchi), .jump(jump), .imm(imm),
    .ld_en(ld_en), .ld_prog(ld_prog), .ld_addr(ld_addr), .ld_data(ld_data),
    .pc_o(pc_o), .prog_o(prog_o), .inst_o(inst_o), .inst_valid(inst_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // reference model: programs wrap 1..3, PC arithmetic mod 256, read-before-write memory
  always @(posedge clk) begin
    int sgn, mag;
    if (reset) begin
      m_pc = 0; m_prog = 0; m_inst = 0; m_cnt = 0;
    end else if (init) begin
      m_prog = m_prog % 3 + 1;
      m_pc = start_addr;
      m_cnt = 0;
      m_inst = m_mem[m_prog][m_pc];
    end else if (fetch_en) begin
      if (branch) m_pc = target;
      else if (branchi) begin
        sgn = jump ? (imm >> 5) & 1 : (imm >> 3) & 1;
        mag = jump ? imm % 32 : imm % 8;
        m_pc = (m_pc + (sgn ? -mag : mag) + 256) % 256;
      end else m_pc = (m_pc + 1) % 256;
      m_cnt = m_cnt == 65535 ? 65535 : m_cnt + 1;
      m_inst = m_prog == 0 ? 0 : m_mem[m_prog][m_pc];
    end
    if (ld_en && ld_prog >= 1 && ld_prog <= 3) m_mem[ld_prog][ld_addr] = ld_data;
  end

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_pc", pc_o, m_pc);
      chk("model_prog", prog_o, m_prog);
      chk("model_inst", inst_o, m_inst);
      chk("model_valid", inst_valid, m_prog != 0);
      chk("model_cnt", fetch_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    init = 0; start_addr = 0; fetch_en = 0; branch = 0; target = 0;
    branchi = 0; jump = 0; imm = 0; ld_en = 0; ld_prog = 0; ld_addr = 0; ld_data = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    tick();
    chk_on = 1;
    for (int p = 1; p <= 3; p++)
      for (int a = 0; a < 256; a++) begin
        ld_en = 1; ld_prog = 2'(p); ld_addr = 8'(a); ld_data = 9'((p - 1) * 'hA5 + a + 1);
        tick();
      end
    ld_en = 0;
    chk("rst_pc", pc_o, 0); chk("rst_inst", inst_o, 0);
    chk("rst_valid", inst_valid, 0); chk("rst_cnt", fetch_cnt, 0);
    reset = 0; init = 1; start_addr = 0;
    tick();
    init = 0;
    chk("init_prog", prog_o, 1); chk("init_pc", pc_o, 0); chk("init_inst", inst_o, 9'h001);
    chk("init_valid", inst_valid, 1); chk("init_cnt", fetch_cnt, 0);
    fetch_en = 1;
    repeat (3) tick();
    chk("seq_pc", pc_o, 3); chk("seq_inst", inst_o, 9'h004); chk("seq_cnt", fetch_cnt, 3);
    branch = 1; target = 10;
    tick();
    branch = 0;
    chk("br10_pc", pc_o, 10); chk("br10_inst", inst_o, 9'h00B);
    branchi = 1; jump = 1; imm = 6'b100011;
    tick();
    chk("jump_back_pc", pc_o, 7); chk("jump_back_inst", inst_o, 9'h008);
    jump = 0; imm = 6'b110101;
    tick();
    chk("short_fwd_pc", pc_o, 12); chk("short_fwd_inst", inst_o, 9'h00D);
    branch = 1; target = 8'h40;
    tick();
    branchi = 0;
    chk("br_over_bi_pc", pc_o, 8'h40); chk("br_over_bi_inst", inst_o, 9'h041);
    target = 255;
    tick();
    branch = 0;
    chk("pc255", pc_o, 255); chk("inst255", inst_o, 9'h100);
    tick();
    chk("wrap_pc", pc_o, 0); chk("wrap_inst", inst_o, 9'h001);
    branch = 1; target = 2;
    tick();
    branch = 0; branchi = 1; jump = 0; imm = 6'b001101;
    tick();
    branchi = 0;
    chk("neg_wrap_pc", pc_o, 253); chk("neg_wrap_inst", inst_o, 9'h0FE); chk("cnt11", fetch_cnt, 11);
    fetch_en = 0; branch = 1; target = 5;
    repeat (4) tick();
    chk("stall_pc", pc_o, 253); chk("stall_inst", inst_o, 9'h0FE); chk("stall_cnt", fetch_cnt, 11);
    fetch_en = 1; target = 253; ld_en = 1; ld_prog = 1; ld_addr = 253; ld_data = 9'h1AA;
    tick();
    ld_en = 0;
    chk("rd_first_inst", inst_o, 9'h0FE);
    tick();
    chk("new_word_inst", inst_o, 9'h1AA);
    fetch_en = 0; branch = 0; ld_en = 1; ld_prog = 0; ld_data = 9'h055;
    tick();
    ld_en = 0; fetch_en = 1; branch = 1;
    tick();
    fetch_en = 0; branch = 0;
    chk("ldprog0_dropped", inst_o, 9'h1AA);
    init = 1; start_addr = 8'h20;
    tick();
    chk("prog2", prog_o, 2); chk("prog2_pc", pc_o, 8'h20); chk("prog2_inst", inst_o, 9'h0C6);
    chk("prog2_cnt", fetch_cnt, 0);
    fetch_en = 1; branch = 1; target = 8'h99; start_addr = 253;
    tick();
    fetch_en = 0; branch = 0;
    chk("prog3", prog_o, 3); chk("init_wins_pc", pc_o, 253); chk("prog3_inst", inst_o, 9'h048);
    start_addr = 8'h10;
    tick();
    chk("prog_wrap", prog_o, 1); chk("prog_wrap_pc", pc_o, 8'h10); chk("prog_wrap_inst", inst_o, 9'h011);
    start_addr = 8'h33;
    tick();
    init = 0;
    chk("pre_rst_prog", prog_o, 2); chk("pre_rst_inst", inst_o, 9'h0D9);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_pc", pc_o, 0); chk("mid_rst_prog", prog_o, 0); chk("mid_rst_inst", inst_o, 0);
    chk("mid_rst_valid", inst_valid, 0); chk("mid_rst_cnt", fetch_cnt, 0);
    init = 1; start_addr = 0;
    tick();
    init = 0;
    chk("post_rst_prog", prog_o, 1); chk("post_rst_inst", inst_o, 9'h001);
    fetch_en = 1;
    tick();
    fetch_en = 0;
    chk("post_rst_fetch", inst_o, 9'h002);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
